// File: rtl/lamp_input_conditioner.sv
// Lamp-switch conditioner: 2-flop synchronizer, whole-code debounce and a one-cycle NOVO strobe.
// Optional accepted-change counter on EVT_CNT, enabled by defining LAMP_EVT_COUNT_EN.
module lamp_input_conditioner #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] SW,
  output logic [1:0] X,
  output logic       NOVO,
  output logic       ESTAVEL
`ifdef LAMP_EVT_COUNT_EN
  ,
  output logic [7:0] EVT_CNT
`endif
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_cand;
  logic [1:0]    r_x;
  logic [CW-1:0] r_cnt;
  logic          r_novo;

  logic [1:0]    w_cand_nxt;
  logic [1:0]    w_x_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_novo_nxt;

  // A change of the synchronized code restarts the count; the whole 2-bit value is the unit.
  always_comb begin
    w_cand_nxt = r_cand;
    w_x_nxt    = r_x;
    w_cnt_nxt  = r_cnt;
    w_novo_nxt = 1'b0;
    if (r_sync2 != r_cand) begin
      w_cand_nxt = r_sync2;
      w_cnt_nxt  = CNT_ZERO;
    end else if (r_cand != r_x) begin
      if (r_cnt == CNT_LAST) begin
        w_x_nxt    = r_cand;
        w_cnt_nxt  = CNT_ZERO;
        w_novo_nxt = 1'b1;
      end else begin
        w_cnt_nxt  = r_cnt + CNT_ONE;
      end
    end else begin
      w_cnt_nxt = CNT_ZERO;
    end
  end

  // Synchronizer, candidate, debounce counter and accepted code.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_cand  <= 2'b00;
      r_x     <= 2'b00;
      r_cnt   <= CNT_ZERO;
      r_novo  <= 1'b0;
    end else begin
      r_sync1 <= SW;
      r_sync2 <= r_sync1;
      r_cand  <= w_cand_nxt;
      r_x     <= w_x_nxt;
      r_cnt   <= w_cnt_nxt;
      r_novo  <= w_novo_nxt;
    end
  end

`ifdef LAMP_EVT_COUNT_EN
  logic [7:0] r_evt;

  // Saturating count of accepted codes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_evt <= 8'd0;
    end else if (w_novo_nxt && (r_evt != 8'hFF)) begin
      r_evt <= r_evt + 8'd1;
    end else begin
      r_evt <= r_evt;
    end
  end

  assign EVT_CNT = r_evt;
`endif

  assign X       = r_x;
  assign NOVO    = r_novo;
  assign ESTAVEL = (r_sync2 == r_cand) && (r_cand == r_x);

endmodule

// File: tb/tb_lamp_input_conditioner.sv
// Bench for lamp_input_conditioner: history-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_lamp_input_conditioner;

  localparam int DEB  = 16;
  localparam int HMAX = 16384;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] SW  = 2'b00;
  logic [1:0] X;
  logic       NOVO;
  logic       ESTAVEL;
`ifdef LAMP_EVT_COUNT_EN
  logic [7:0] EVT_CNT;
`endif

  lamp_input_conditioner #(.DEB_CYCLES(DEB)) dut (
    .CLK(CLK),
    .RST(RST),
    .SW(SW),
    .X(X),
    .NOVO(NOVO),
    .ESTAVEL(ESTAVEL)
`ifdef LAMP_EVT_COUNT_EN
    ,
    .EVT_CNT(EVT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int npulse = 0;

  // Model: every sampled SW code by edge index; a code is accepted once it has
  // been seen on DEB+1 consecutive samples, two edges of synchronizer latency later.
  logic [1:0] hist [HMAX];
  int         t = 0;
  logic [1:0] mx = 2'b00;
  logic       mnovo = 1'b0;
  int         mevt = 0;
  bit         armed = 1'b0;

  function automatic logic [1:0] h(input int i);
    if (i < 0 || i >= HMAX) return 2'b00;
    return hist[i];
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [1:0] w;
    int         len;
    if (t >= HMAX) begin
      $display("FAIL history_overflow at %0t", $time);
      $fatal(1, "history overflow");
    end
    if (RST) begin
      hist[t] = 2'b00;
      if (t >= 1) hist[t-1] = 2'b00;
      if (t >= 2) hist[t-2] = 2'b00;
      mx    = 2'b00;
      mnovo = 1'b0;
      mevt  = 0;
    end else begin
      hist[t] = SW;
      w   = h(t - 2);
      len = 0;
      for (int k = t - 2; k >= 0 && len <= DEB + 1; k--) begin
        if (hist[k] == w) len++;
        else break;
      end
      mnovo = (len == DEB + 1) && (w != mx);
      if (mnovo) begin
        mx = w;
        if (mevt < 255) mevt++;
      end
    end
    t++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    SW = v;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) tick();
    RST = 1'b0;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (armed) begin
      check("x", {7'd0, X}, {7'd0, mx});
      check("novo", {8'd0, NOVO}, {8'd0, mnovo});
      check("estavel", {8'd0, ESTAVEL},
            {8'd0, ((h(t-2) == h(t-3)) && (h(t-3) == mx))});
`ifdef LAMP_EVT_COUNT_EN
      check("evt_cnt", {1'b0, EVT_CNT}, 9'(mevt));
`endif
      if (NOVO === 1'b1) npulse++;
    end
  end

  initial begin
    int p0;
    do_reset(3);
    armed = 1'b1;
    check("reset_x", {7'd0, X}, 9'd0);
    check("reset_estavel", {8'd0, ESTAVEL}, 9'd1);

    // Idle after reset with 00 held
    p0 = npulse;
    hold(2'b00, 20);
    check("idle_x", {7'd0, X}, 9'd0);
    check("idle_no_novo", 9'(npulse - p0), 9'd0);

    // Clean step 00 -> 01: accepted at edge 18
    SW = 2'b01;
    repeat (2) tick();
    check("step_estavel_low", {8'd0, ESTAVEL}, 9'd0);
    repeat (16) tick();
    check("step_x_edge17", {7'd0, X}, 9'd0);
    tick();
    check("step_x_edge18", {7'd0, X}, 9'd1);
    check("step_novo", {8'd0, NOVO}, 9'd1);
    tick();
    check("step_novo_off", {8'd0, NOVO}, 9'd0);
    check("step_estavel", {8'd0, ESTAVEL}, 9'd1);
    hold(2'b01, 10);

    // Glitch of 10 cycles is discarded
    p0 = npulse;
    hold(2'b10, 10);
    hold(2'b01, 25);
    check("glitch_x", {7'd0, X}, 9'd1);
    check("glitch_no_novo", 9'(npulse - p0), 9'd0);
    check("glitch_estavel", {8'd0, ESTAVEL}, 9'd1);

    // Boundary: DEB samples rejected, DEB+1 accepted
    p0 = npulse;
    hold(2'b10, DEB);
    hold(2'b01, 25);
    check("deb_exact_reject", 9'(npulse - p0), 9'd0);
    hold(2'b10, DEB + 1);
    hold(2'b01, 25);
    check("deb_plus1_accept", 9'(npulse - p0), 9'd2);

    // Sequence 01, 10, 11 from reset
    do_reset(1);
    p0 = npulse;
    hold(2'b01, 40);
    check("seq_x01", {7'd0, X}, 9'd1);
    hold(2'b10, 40);
    check("seq_x10", {7'd0, X}, 9'd2);
    hold(2'b11, 40);
    check("seq_x11", {7'd0, X}, 9'd3);
    check("seq_pulses", 9'(npulse - p0), 9'd3);
`ifdef LAMP_EVT_COUNT_EN
    check("seq_evt", {1'b0, EVT_CNT}, 9'd3);
`endif

    // Reset mid-debounce restarts the full latency
    do_reset(2);
    hold(2'b00, 5);
    SW = 2'b11;
    repeat (10) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    repeat (18) tick();
    check("rst_mid_x_before", {7'd0, X}, 9'd0);
    tick();
    check("rst_mid_x_after", {7'd0, X}, 9'd3);
    hold(2'b11, 5);

    // Short intermediate code on the way 11 -> 00 never reaches X
    p0 = npulse;
    hold(2'b01, 2);
    hold(2'b00, 30);
    check("transient_x", {7'd0, X}, 9'd0);
    check("transient_pulses", 9'(npulse - p0), 9'd1);

    // Saturation: 300 accepted toggles
    do_reset(1);
    p0 = npulse;
    for (int i = 0; i < 300; i++) begin
      hold((i % 2 == 0) ? 2'b01 : 2'b10, 20);
    end
    check("sat_x", {7'd0, X}, 9'd2);
    check("sat_pulses", 9'(npulse - p0), 9'd300);
`ifdef LAMP_EVT_COUNT_EN
    check("sat_evt", {1'b0, EVT_CNT}, 9'd255);
`endif
    hold(2'b01, 20);
`ifdef LAMP_EVT_COUNT_EN
    check("sat_evt_hold", {1'b0, EVT_CNT}, 9'd255);
`endif

    @(negedge CLK);
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lamp_input_conditioner.md
LAMP_INPUT_CONDITIONER -- requirements
Module: lamp_input_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16: number of consecutive clock cycles a new lamp code must remain stable before acceptance. Legal range 2..65535.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port SW, input, 2 bits: raw, asynchronous, bouncing lamp-state switches. SW[1] is lamp X1 and SW[0] is lamp X0.
REQ-005 SHALL have port X, output, 2 bits: debounced lamp code that feeds the downstream 01-10-11 sequence detector.
REQ-006 SHALL have port NOVO, output, 1 bit: one-cycle strobe that marks a newly accepted code on X.
REQ-007 SHALL have port ESTAVEL, output, 1 bit: high when no code change is pending.
REQ-008 SHALL have port EVT_CNT, output, 8 bits: accepted-change count. The port is present only with LAMP_EVT_COUNT_EN.

Function
REQ-009 SHALL pass SW through a two-stage register synchronizer, sync1 then sync2, both 2 bits wide, before any other use.
REQ-010 SHALL hold a 2-bit candidate register cand and a debounce counter cnt of width ceil(log2(DEB_CYCLES)).
REQ-011 SHALL apply the following priority at each edge when RST is low:
- sync2 != cand: cand <= sync2, cnt <= 0.
- Otherwise, cand != X and cnt == DEB_CYCLES-1: X <= cand, cnt <= 0, NOVO <= 1.
- Otherwise, cand != X: cnt <= cnt+1.
- Otherwise: cnt <= 0.
REQ-012 SHALL drive NOVO low on every cycle not covered by REQ-011, so NOVO is never high for two consecutive cycles.
REQ-013 SHALL set X to a new SW value exactly at edge 2+DEB_CYCLES, counting the first edge that samples that value as edge 0, provided SW stays constant. NOVO SHALL be high for the cycle following that edge.
REQ-014 SHALL discard any SW excursion that lasts fewer than DEB_CYCLES cycles after synchronization: X unchanged, no NOVO.
REQ-015 SHALL treat the 2-bit code as one value. Transient intermediate codes, such as 01 during a 00->11 transition, SHALL restart the count and never appear on X unless they persist.
REQ-016 SHALL clear cnt without a NOVO strobe when a bounce returns to the current X value before acceptance.
REQ-017 SHALL drive ESTAVEL = (sync2 == cand) AND (cand == X), combinationally from registers only.
REQ-018 SHALL have a cnt that never exceeds DEB_CYCLES-1 and never wraps.

Reset
REQ-019 SHALL, on any edge with RST high, set sync1, sync2, cand and X to 2'b00, cnt to 0, NOVO to 0 and EVT_CNT to 0. Reset overrides all other updates.
REQ-020 SHALL abandon a debounce in progress when RST is asserted mid-count. After release, the pending SW value requires the full 2+DEB_CYCLES edges again.
REQ-021 SHALL have ESTAVEL = 1 and X = 00 in the first cycle after reset.

Configuration
REQ-022 SHALL use the macro LAMP_EVT_COUNT_EN.
- Defined: EVT_CNT exists, increments by 1 on each edge at which NOVO is set, and saturates at 255.
- Undefined: the port and counter logic are absent, and all other behaviour is identical.

Verification
REQ-023 SHALL cover reset release with SW=00 held: X=00, NOVO never high, ESTAVEL=1.
REQ-024 SHALL cover a clean step, DEB_CYCLES=16, SW 00->01 sampled at edge 0: X=01 after edge 18, NOVO high for exactly one cycle, ESTAVEL low over edges 1..18.
REQ-025 SHALL cover a glitch, DEB_CYCLES=16, X=01: SW=10 for 10 cycles, then back to 01. X stays 01, no NOVO, and ESTAVEL returns high.
REQ-026 SHALL cover the sequence 01, 10, 11 with each value held 40 cycles, with LAMP_EVT_COUNT_EN defined: three NOVO pulses, X follows 01, 10, 11, and EVT_CNT=3.
REQ-027 SHALL cover reset mid-debounce: SW=11 from X=00, then RST pulsed high 1 cycle at edge 10. X=00 until 18 edges after release, then X=11.
REQ-028 SHALL cover saturation: 300 accepted toggles between 01 and 10 with LAMP_EVT_COUNT_EN defined. EVT_CNT=255 and stays 255.
